// File: rtl/gray_sync_pkg.sv
//------------------------------------------------------------------------------
// Module      : gray_sync_pkg
// Description : Gray/binary conversion helpers and sync-depth limits.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gray_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int CONV_WIDTH      = 32;

    typedef logic [CONV_WIDTH-1:0] word_t;

    // Callers zero-extend narrower pointers; leading zeros leave the prefix XOR unchanged.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[CONV_WIDTH-1] = g[CONV_WIDTH-1];
        for (int i = CONV_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
//------------------------------------------------------------------------------
// Module      : sync_chain
// Description : Multi-flop synchroniser chain, asynchronous active-high reset.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage[0] <= '0;
        end else begin
            stage[0] <= din;
        end
    end

    genvar k;
    generate
        for (k = 1; k < STAGES; k++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage[k] <= '0;
                end else begin
                    stage[k] <= stage[k-1];
                end
            end
        end
    endgenerate

    assign dout = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_ptr_sync.sv
//------------------------------------------------------------------------------
// Module      : gray_ptr_sync
// Description : Gray pointer CDC synchroniser with binary view, update pulse,
//               step delta and sticky multi-bit-change checker.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gray_ptr_sync
    import gray_sync_pkg::*;
#(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_EN    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PTR_WIDTH:0] gray_in,
    input  logic               err_clr,
    output logic [PTR_WIDTH:0] gray_out,
    output logic [PTR_WIDTH:0] bin_out,
    output logic               upd,
    output logic [PTR_WIDTH:0] delta,
    output logic               err
);

    localparam int W = PTR_WIDTH + 1;

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("gray_ptr_sync: SYNC_STAGES must be within 2..4");
        end
        if (W > CONV_WIDTH) begin : g_bad_width
            $error("gray_ptr_sync: PTR_WIDTH too large for conversion helpers");
        end
    endgenerate

    logic [W-1:0] prev;
    logic [W-1:0] bin_new;
    logic [W-1:0] bin_prev;
    logic         change;
    logic         step_err;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk  (clk),
        .rst  (rst),
        .din  (gray_in),
        .dout (gray_out)
    );

    always_comb begin
        bin_new  = W'(gray2bin(word_t'(gray_out)));
        bin_prev = W'(gray2bin(word_t'(prev)));
        change   = (gray_out != prev);
        step_err = (CHECK_EN != 0) && change && ($countones(gray_out ^ prev) > 1);
    end

    // A bad step is still forwarded; the checker only flags it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            bin_out <= '0;
            upd     <= 1'b0;
            delta   <= '0;
            err     <= 1'b0;
        end else begin
            prev    <= gray_out;
            bin_out <= bin_new;
            upd     <= change;
            delta   <= change ? (bin_new - bin_prev) : '0;
            if (step_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
